crypto_input_arbiter: RTL
=========================

# crypto_input_arbiter

Packet-granular round-robin arbiter that shares the single crypto datapath among NUM_QUEUES AXI-Stream input queues. It sits between the input queues and the crypto block's slave stream port. Once a queue is granted, the arbiter holds the grant until that packet's last beat transfers. It also applies a software queue-enable mask and keeps a wrapping packet counter per queue.

## Interface
Parameters:
- NUM_QUEUES, 4, number of input queues (2..8)
- C_AXIS_DATA_WIDTH, 256, tdata width of every stream
- C_AXIS_TUSER_WIDTH, 128, tuser width of every stream
- CNT_WIDTH, 32, width of each per-queue packet counter

Ports (all ports are synchronous to one clock; reset is asynchronous and active-low):
- axis_aclk  in  1  clock
- axis_resetn  in  1  asynchronous, active-low reset
- s_axis_tdata  in  NUM_QUEUES*C_AXIS_DATA_WIDTH  flattened tdata; queue i occupies slice i
- s_axis_tkeep  in  NUM_QUEUES*C_AXIS_DATA_WIDTH/8  flattened tkeep
- s_axis_tuser  in  NUM_QUEUES*C_AXIS_TUSER_WIDTH  flattened tuser
- s_axis_tvalid  in  NUM_QUEUES  per-queue tvalid
- s_axis_tlast  in  NUM_QUEUES  per-queue tlast
- s_axis_tready  out  NUM_QUEUES  per-queue tready
- m_axis_tdata  out  C_AXIS_DATA_WIDTH  tdata toward the crypto datapath
- m_axis_tkeep  out  C_AXIS_DATA_WIDTH/8  tkeep toward the crypto datapath
- m_axis_tuser  out  C_AXIS_TUSER_WIDTH  tuser toward the crypto datapath
- m_axis_tvalid  out  1  tvalid toward the crypto datapath
- m_axis_tlast  out  1  tlast toward the crypto datapath
- m_axis_tready  in  1  backpressure from the crypto datapath
- cfg_queue_en  in  NUM_QUEUES  queue eligible for grant when bit = 1
- grant_idx  out  $clog2(NUM_QUEUES)  currently or last granted queue
- pkt_count  out  NUM_QUEUES*CNT_WIDTH  flattened per-queue count of completed packets

## Operation
The arbiter has two states, IDLE and PKT.

- **IDLE**
  - All s_axis_tready are 0 and m_axis_tvalid is 0.
  - Eligible queues are those with s_axis_tvalid[i] & cfg_queue_en[i].
  - Search order starts at grant_idx+1, modulo NUM_QUEUES, and wraps.
  - If any queue is eligible, register the first eligible index into grant_idx and go to PKT.
  - If none is eligible, stay in IDLE.
- **PKT** (selected queue g = grant_idx)
  - m_axis_tdata, m_axis_tkeep, m_axis_tuser, m_axis_tlast and m_axis_tvalid are combinationally muxed from queue g.
  - s_axis_tready[g] = m_axis_tready; every other tready is 0.
  - A beat transfers when m_axis_tvalid & m_axis_tready.
  - On a transfer with m_axis_tlast = 1: increment pkt_count[g], wrapping to 0 at 2^CNT_WIDTH, and go to IDLE.
- tuser is passed through unmodified.
- cfg_queue_en is sampled only in IDLE. Clearing the granted queue's bit mid-packet does not truncate the packet.
- A queue whose tvalid drops mid-packet stalls the arbiter in PKT. No timeout exists.
- Reset asserted mid-packet: state and outputs clear immediately and the partial packet is abandoned. Cleanup is the upstream's responsibility.

## Timing
- Reset values: state IDLE, grant_idx = NUM_QUEUES-1 (so queue 0 has first priority), all pkt_count = 0, s_axis_tready = 0, m_axis_tvalid = 0.
- m_axis data, tkeep, tuser and tlast outputs read as 0 while in IDLE.
- Grant latency: the first beat can transfer in the cycle after tvalid is first seen in IDLE (1 cycle).
- Data path latency in PKT: 0 cycles, pure mux with no registers.
- Every packet boundary costs exactly one IDLE bubble cycle. Back-to-back packets achieve N/(N+1) beat throughput for N-beat packets.
- A single-beat packet takes 2 cycles: IDLE, then PKT with the transfer.
- pkt_count updates on the clock edge that ends the tlast transfer.
- grant_idx updates on the IDLE→PKT edge.

## Structure
- Shared package crypto_arb_pkg holds:
  - the state encoding (ARB_IDLE, ARB_PKT);
  - defaults for NUM_QUEUES and CNT_WIDTH;
  - a function computing the index width.
- One natural sub-module, rr_priority_picker:
  - inputs: request vector and last index;
  - outputs: next index and a found flag;
  - purely combinational rotate-and-priority-encode.
- Top level contains the FSM, the output mux and the counters.

## Test plan
- After reset, queues 0 and 2 each present a 3-beat packet at the same time with cfg_queue_en = 4'b1111. Required: queue 0 goes first, then queue 2; grant_idx reads 0 then 2; pkt_count[0] = pkt_count[2] = 1; 8 cycles total.
- All 4 queues continuously offer 1-beat packets. Required: grant order 0,1,2,3,0,…; each transfer is separated by one IDLE cycle.
- cfg_queue_en = 4'b1101 with queue 1 valid only. Required: no grant; m_axis_tvalid stays 0 and s_axis_tready[1] stays 0.
- m_axis_tready toggles 1,0,0,1 in the middle of a 4-beat packet from queue 3. Required:
  - all 4 beats are delivered in order;
  - s_axis_tready[3] tracks m_axis_tready;
  - the other queues' tready stay 0.
- Preload pkt_count[1] to 2^CNT_WIDTH-1 (use CNT_WIDTH = 4 and send 15 packets first), then send one more packet. Required: pkt_count[1] wraps to 0.
- Assert axis_resetn low on beat 2 of a 5-beat packet. Required: m_axis_tvalid and all s_axis_tready drop within the same cycle; after release, grant_idx = NUM_QUEUES-1 and all counters are 0.

Source files
------------

// File: rtl/crypto_arb_pkg.sv
// rtl/crypto_arb_pkg.sv - shared types and defaults for the crypto input arbiter
package crypto_arb_pkg;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_PKT  = 1'b1
    } arb_state_e;

    localparam int DEF_NUM_QUEUES = 4;
    localparam int DEF_CNT_WIDTH  = 32;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/crypto_input_arbiter_if.sv
// rtl/crypto_input_arbiter_if.sv - input queue streams and crypto-side stream bundle
interface crypto_input_arbiter_if
    import crypto_arb_pkg::*;
#(
    parameter int NUM_QUEUES         = DEF_NUM_QUEUES,
    parameter int C_AXIS_DATA_WIDTH  = 256,
    parameter int C_AXIS_TUSER_WIDTH = 128
);
    logic [NUM_QUEUES*C_AXIS_DATA_WIDTH-1:0]     s_axis_tdata;
    logic [NUM_QUEUES*C_AXIS_DATA_WIDTH/8-1:0]   s_axis_tkeep;
    logic [NUM_QUEUES*C_AXIS_TUSER_WIDTH-1:0]    s_axis_tuser;
    logic [NUM_QUEUES-1:0]                       s_axis_tvalid;
    logic [NUM_QUEUES-1:0]                       s_axis_tlast;
    logic [NUM_QUEUES-1:0]                       s_axis_tready;
    logic [C_AXIS_DATA_WIDTH-1:0]                m_axis_tdata;
    logic [C_AXIS_DATA_WIDTH/8-1:0]              m_axis_tkeep;
    logic [C_AXIS_TUSER_WIDTH-1:0]               m_axis_tuser;
    logic                                        m_axis_tvalid;
    logic                                        m_axis_tlast;
    logic                                        m_axis_tready;

    // master: queues plus crypto sink; slave: the arbiter itself
    modport master (
        output s_axis_tdata, s_axis_tkeep, s_axis_tuser, s_axis_tvalid, s_axis_tlast,
        output m_axis_tready,
        input  s_axis_tready,
        input  m_axis_tdata, m_axis_tkeep, m_axis_tuser, m_axis_tvalid, m_axis_tlast
    );

    modport slave (
        input  s_axis_tdata, s_axis_tkeep, s_axis_tuser, s_axis_tvalid, s_axis_tlast,
        input  m_axis_tready,
        output s_axis_tready,
        output m_axis_tdata, m_axis_tkeep, m_axis_tuser, m_axis_tvalid, m_axis_tlast
    );

endinterface

// File: rtl/rr_priority_picker.sv
// rtl/rr_priority_picker.sv - rotate-and-priority-encode starting after the last index
module rr_priority_picker
    import crypto_arb_pkg::*;
#(
    parameter int NUM_QUEUES = DEF_NUM_QUEUES,
    parameter int IDX_W      = idx_width(NUM_QUEUES)
) (
    input  logic [NUM_QUEUES-1:0] req,
    input  logic [IDX_W-1:0]      last_idx,
    output logic [IDX_W-1:0]      next_idx,
    output logic                  found
);

    always_comb begin
        int              cand;
        logic [IDX_W-1:0] cand_idx;
        next_idx = last_idx;
        found    = 1'b0;
        cand     = 0;
        cand_idx = '0;
        // k = NUM_QUEUES lands back on last_idx, so it has lowest priority
        for (int k = 1; k <= NUM_QUEUES; k++) begin
            cand     = (int'(last_idx) + k) % NUM_QUEUES;
            cand_idx = cand[IDX_W-1:0];
            if (!found && req[cand_idx]) begin
                next_idx = cand_idx;
                found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/crypto_input_arbiter.sv
// rtl/crypto_input_arbiter.sv - packet-granular round-robin arbiter onto the crypto datapath
module crypto_input_arbiter
    import crypto_arb_pkg::*;
#(
    parameter int NUM_QUEUES         = DEF_NUM_QUEUES,
    parameter int C_AXIS_DATA_WIDTH  = 256,
    parameter int C_AXIS_TUSER_WIDTH = 128,
    parameter int CNT_WIDTH          = DEF_CNT_WIDTH
) (
    input  logic                            axis_aclk,
    input  logic                            axis_resetn,
    crypto_input_arbiter_if.slave           bus,
    input  logic [NUM_QUEUES-1:0]           cfg_queue_en,
    output logic [$clog2(NUM_QUEUES)-1:0]   grant_idx,
    output logic [NUM_QUEUES*CNT_WIDTH-1:0] pkt_count
);

    localparam int IDX_W  = idx_width(NUM_QUEUES);
    localparam int DW     = C_AXIS_DATA_WIDTH;
    localparam int KW     = C_AXIS_DATA_WIDTH / 8;
    localparam int UW     = C_AXIS_TUSER_WIDTH;

    arb_state_e           state, state_nxt;
    logic [IDX_W-1:0]     pick_idx;
    logic                 pick_found;
    logic                 sel_valid;
    logic                 sel_last;
    logic                 xfer_last;
    logic [CNT_WIDTH-1:0] cnt [NUM_QUEUES];

    rr_priority_picker #(
        .NUM_QUEUES (NUM_QUEUES),
        .IDX_W      (IDX_W)
    ) u_picker (
        .req      (bus.s_axis_tvalid & cfg_queue_en),
        .last_idx (grant_idx),
        .next_idx (pick_idx),
        .found    (pick_found)
    );

    always_ff @(posedge axis_aclk or negedge axis_resetn) begin
        if (!axis_resetn) begin
            state     <= ARB_IDLE;
            grant_idx <= IDX_W'(NUM_QUEUES - 1);
            for (int i = 0; i < NUM_QUEUES; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            state <= state_nxt;
            if (state == ARB_IDLE && pick_found) begin
                grant_idx <= pick_idx;
            end
            if (xfer_last) begin
                cnt[grant_idx] <= cnt[grant_idx] + CNT_WIDTH'(1);
            end
        end
    end

    // Grant is held until the tlast beat; the enable mask only matters in IDLE
    always_comb begin
        state_nxt         = state;
        sel_valid         = 1'b0;
        sel_last          = 1'b0;
        xfer_last         = 1'b0;
        bus.s_axis_tready = '0;
        bus.m_axis_tdata  = '0;
        bus.m_axis_tkeep  = '0;
        bus.m_axis_tuser  = '0;
        bus.m_axis_tvalid = 1'b0;
        bus.m_axis_tlast  = 1'b0;
        case (state)
            ARB_IDLE: begin
                if (pick_found) begin
                    state_nxt = ARB_PKT;
                end
            end
            ARB_PKT: begin
                sel_valid                    = bus.s_axis_tvalid[grant_idx];
                sel_last                     = bus.s_axis_tlast[grant_idx];
                bus.m_axis_tdata             = bus.s_axis_tdata[grant_idx*DW +: DW];
                bus.m_axis_tkeep             = bus.s_axis_tkeep[grant_idx*KW +: KW];
                bus.m_axis_tuser             = bus.s_axis_tuser[grant_idx*UW +: UW];
                bus.m_axis_tvalid            = sel_valid;
                bus.m_axis_tlast             = sel_last;
                bus.s_axis_tready[grant_idx] = bus.m_axis_tready;
                xfer_last = sel_valid & bus.m_axis_tready & sel_last;
                if (xfer_last) begin
                    state_nxt = ARB_IDLE;
                end
            end
            default: state_nxt = ARB_IDLE;
        endcase
    end

    for (genvar i = 0; i < NUM_QUEUES; i++) begin : g_cnt_out
        assign pkt_count[i*CNT_WIDTH +: CNT_WIDTH] = cnt[i];
    end

endmodule
